// File: rtl/wishbone_ram_target_if.sv
// Pipelined Wishbone B4 bus bundle between an initiator and a memory target.
// The master drives requests; the slave returns ACK/ERR/RTY, data, tag and STALL.
interface wishbone_ram_target_if #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 32,
  parameter int Granularity  = 8,
  parameter int TGDWidth     = 1,
  parameter int TGAWidth     = 1,
  parameter int TGCWidth     = 1
);
  localparam int SELWidth = DataWidth / Granularity;

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [AddressWidth-1:0] addr;
  logic [SELWidth-1:0]     sel;
  logic [DataWidth-1:0]    dat_to_target;
  logic [TGDWidth-1:0]     tgd_to_target;
  logic                    lock;
  logic [TGAWidth-1:0]     tga;
  logic [TGCWidth-1:0]     tgc;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DataWidth-1:0]    dat_to_initiator;
  logic [TGDWidth-1:0]     tgd_to_initiator;
  logic                    ack;
  logic                    err;
  logic                    rty;
  logic                    stall;

  modport master (
    output cyc, stb, we, addr, sel, dat_to_target, tgd_to_target,
           lock, tga, tgc, cti, bte,
    input  dat_to_initiator, tgd_to_initiator, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, addr, sel, dat_to_target, tgd_to_target,
           lock, tga, tgc, cti, bte,
    output dat_to_initiator, tgd_to_initiator, ack, err, rty, stall
  );
endinterface

// File: rtl/wishbone_ram_target.sv
// Pipelined Wishbone B4 target backed by a single-port synchronous RAM.
// Fixed-latency in-order responses; STALL caps the number of outstanding requests.
module wishbone_ram_target #(
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 32,
  parameter int Granularity    = 8,
  parameter int TGDWidth       = 1,
  parameter int Depth          = 256,
  parameter int Latency        = 3,
  parameter int MaxOutstanding = 2
) (
  input logic                   clk,
  input logic                   rst,
  wishbone_ram_target_if.slave  bus
);
  localparam int SelWidth = DataWidth / Granularity;
  localparam int IdxWidth = $clog2(Depth);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int Last     = Latency - 1;

  logic [DataWidth-1:0] mem [Depth];

  logic [Latency-1:0]   pipe_valid;
  logic [Latency-1:0]   pipe_err;
  logic [DataWidth-1:0] pipe_data [Latency];
  logic [TGDWidth-1:0]  pipe_tag  [Latency];
  logic [CntWidth-1:0]  outstanding;

  logic                 in_range;
  logic                 accept;
  logic                 resp_now;
  logic [IdxWidth-1:0]  idx;
  logic                 unused_inputs;

  // Extra top bit keeps the compare correct when Depth fills the whole address space.
  assign in_range = {1'b0, bus.addr} < (AddressWidth + 1)'(Depth);
  assign idx      = bus.addr[IdxWidth-1:0];

  assign resp_now  = pipe_valid[Last] & bus.cyc & ~rst;
  assign bus.stall = bus.cyc & (outstanding == CntWidth'(MaxOutstanding)) & ~resp_now;
  assign accept    = bus.cyc & bus.stb & ~bus.stall & ~rst;

  assign bus.ack              = resp_now & ~pipe_err[Last];
  assign bus.err              = resp_now &  pipe_err[Last];
  assign bus.rty              = 1'b0;
  assign bus.dat_to_initiator = resp_now ? pipe_data[Last] : '0;
  assign bus.tgd_to_initiator = resp_now ? pipe_tag[Last]  : '0;

  assign unused_inputs = ^{bus.lock, bus.tga, bus.tgc, bus.cti, bus.bte};

  always_ff @(posedge clk) begin
    if (accept && bus.we && in_range) begin
      for (int i = 0; i < SelWidth; i++) begin
        if (bus.sel[i]) begin
          mem[idx][i*Granularity +: Granularity] <= bus.dat_to_target[i*Granularity +: Granularity];
        end
      end
    end
  end

  // Dropping CYC abandons pending responses; writes already in RAM stay committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid  <= '0;
      pipe_err    <= '0;
      outstanding <= '0;
      for (int k = 0; k < Latency; k++) begin
        pipe_data[k] <= '0;
        pipe_tag[k]  <= '0;
      end
    end else if (!bus.cyc) begin
      pipe_valid  <= '0;
      outstanding <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= ~in_range;
      pipe_data[0]  <= (accept && !bus.we && in_range) ? mem[idx] : '0;
      pipe_tag[0]   <= bus.tgd_to_target;
      for (int k = 1; k < Latency; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_err[k]   <= pipe_err[k-1];
        pipe_data[k]  <= pipe_data[k-1];
        pipe_tag[k]   <= pipe_tag[k-1];
      end
      outstanding <= outstanding + CntWidth'(accept) - CntWidth'(resp_now);
    end
  end
endmodule

// File: tb/tb_wishbone_ram_target.sv
// Bench for wishbone_ram_target: table-driven cycles plus a response scoreboard
// built from a reference memory and an in-order pending-response queue.
module tb_wishbone_ram_target;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int MAXO  = 2;

  typedef struct {
    logic        cyc, stb, we;
    logic [15:0] addr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        tgd;
    logic        chk_stall, exp_stall;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] dat;
    logic        tgd;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_ram_target_if #(.AddressWidth(AW), .DataWidth(DW), .Granularity(8),
                           .TGDWidth(1), .TGAWidth(1), .TGCWidth(1)) bus ();

  wishbone_ram_target #(.AddressWidth(AW), .DataWidth(DW), .Granularity(8), .TGDWidth(1),
                        .Depth(DEPTH), .Latency(LAT), .MaxOutstanding(MAXO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] refmem [DEPTH];
  sb_t         sbq [$];
  vec_t        tbl [$];
  int          cyc_n  = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(logic c, logic s, logic w, logic [15:0] a, logic [3:0] sl,
                              logic [31:0] d, logic t, logic cs, logic es,
                              logic cr, logic [31:0] er);
    vec_t v;
    v.cyc = c; v.stb = s; v.we = w; v.addr = a; v.sel = sl; v.dat = d; v.tgd = t;
    v.chk_stall = cs; v.exp_stall = es; v.chk_rd = cr; v.exp_rd = er;
    return v;
  endfunction

  function automatic logic [31:0] pre(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input logic r, output logic acc);
    logic resp_exp, stall_exp;
    sb_t  e;
    rst               = r;
    bus.cyc           = v.cyc;
    bus.stb           = v.stb;
    bus.we            = v.we;
    bus.addr          = v.addr;
    bus.sel           = v.sel;
    bus.dat_to_target = v.dat;
    bus.tgd_to_target = v.tgd;
    #1;
    resp_exp  = !r && v.cyc && sbq.size() > 0 && sbq[0].due == cyc_n;
    stall_exp = v.cyc && sbq.size() == MAXO && !resp_exp;
    check("stall", 64'(bus.stall), 64'(stall_exp));
    if (v.chk_stall) check("stall_tbl", 64'(bus.stall), 64'(v.exp_stall));
    check("rty", 64'(bus.rty), 64'd0);
    if (resp_exp) begin
      e = sbq.pop_front();
      check("ack", 64'(bus.ack), 64'(!e.err));
      check("err", 64'(bus.err), 64'(e.err));
      check("rdat", 64'(bus.dat_to_initiator), 64'(e.dat));
      check("tgd", 64'(bus.tgd_to_initiator), 64'(e.tgd));
      if (e.chk_rd) check("rdat_tbl", 64'(bus.dat_to_initiator), 64'(e.exp_rd));
    end else begin
      check("idle", {30'd0, bus.ack, bus.err, bus.dat_to_initiator}, 64'd0);
      check("idle_tgd", 64'(bus.tgd_to_initiator), 64'd0);
    end
    acc = !r && v.cyc && v.stb && !stall_exp;
    if (acc) begin
      e.due    = cyc_n + LAT;
      e.err    = v.addr >= 16'(DEPTH);
      e.dat    = (!v.we && !e.err) ? refmem[v.addr[7:0]] : 32'd0;
      e.tgd    = v.tgd;
      e.chk_rd = v.chk_rd;
      e.exp_rd = v.exp_rd;
      if (v.we && !e.err)
        for (int i = 0; i < 4; i++)
          if (v.sel[i]) refmem[v.addr[7:0]][i*8 +: 8] = v.dat[i*8 +: 8];
      sbq.push_back(e);
    end
    @(posedge clk);
    if (r || !v.cyc) sbq.delete();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic issue(input vec_t v);
    logic a;
    a = 1'b0;
    for (int t = 0; t < 8 && !a; t++) step(v, 1'b0, a);
  endtask

  task automatic drain();
    logic a;
    repeat (LAT + 1) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, a);
  endtask

  initial begin
    logic a;
    vec_t idle_v, off_v;
    idle_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    off_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.addr = '0; bus.sel = '0;
    bus.dat_to_target = '0; bus.tgd_to_target = '0;
    bus.lock = 0; bus.tga = '0; bus.tgc = '0; bus.cti = '0; bus.bte = '0;
    @(negedge clk);

    // reset for two cycles, then idle with CYC low
    step(off_v, 1'b1, a);
    step(off_v, 1'b1, a);
    step(off_v, 1'b0, a);
    step(off_v, 1'b0, a);

    // preload words 0..5
    for (int i = 0; i < 6; i++) issue(mk(1, 1, 1, 16'(i), 4'hF, pre(i), 1'(i), 0, 0, 0, 0));
    drain();

    // byte-lane merge: full write, lane-1 write, read back
    tbl.push_back(mk(1, 1, 1, 16'h10, 4'hF, 32'hDEADBEEF, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 16'h10, 4'h2, 32'h00005500, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h10, 4'h0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h10, 4'h0, 0, 1, 1, 0, 1, 32'hDEAD55EF));
    foreach (tbl[i]) step(tbl[i], 1'b0, a);
    drain();

    // back-to-back reads with STALL throttling to two outstanding
    tbl.delete();
    tbl.push_back(mk(1, 1, 0, 16'd0, 4'hF, 0, 0, 1, 0, 1, pre(0)));
    tbl.push_back(mk(1, 1, 0, 16'd1, 4'hF, 0, 1, 1, 0, 1, pre(1)));
    tbl.push_back(mk(1, 1, 0, 16'd2, 4'hF, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'd2, 4'hF, 0, 0, 1, 0, 1, pre(2)));
    tbl.push_back(mk(1, 1, 0, 16'd3, 4'hF, 0, 1, 1, 0, 1, pre(3)));
    tbl.push_back(mk(1, 1, 0, 16'd4, 4'hF, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'd4, 4'hF, 0, 0, 1, 0, 1, pre(4)));
    tbl.push_back(mk(1, 1, 0, 16'd5, 4'hF, 0, 1, 1, 0, 1, pre(5)));
    foreach (tbl[i]) step(tbl[i], 1'b0, a);
    drain();

    // out-of-range read errors with tag echoed; in-range read follows; SEL=0 write
    issue(mk(1, 1, 0, 16'h0100, 4'hF, 0, 1, 0, 0, 1, 32'd0));
    issue(mk(1, 1, 0, 16'h0003, 4'hF, 0, 0, 0, 0, 1, pre(3)));
    issue(mk(1, 1, 1, 16'h0003, 4'h0, 32'hFFFFFFFF, 1, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 16'h0003, 4'h1, 0, 1, 0, 0, 1, pre(3)));
    drain();

    // abort: two reads, then CYC drops with a stray STB write that must be ignored
    issue(mk(1, 1, 0, 16'd1, 4'hF, 0, 1, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 16'd2, 4'hF, 0, 1, 0, 0, 0, 0));
    repeat (5) step(mk(0, 1, 1, 16'd5, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 0), 1'b0, a);
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0, a);
    issue(mk(1, 1, 0, 16'd5, 4'hF, 0, 0, 1, 0, 1, pre(5)));
    issue(mk(1, 1, 0, 16'd4, 4'hF, 0, 1, 1, 0, 1, pre(4)));
    drain();

    // reset while two responses are pending, then write/read 0x20
    issue(mk(1, 1, 0, 16'd0, 4'hF, 0, 1, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 16'd1, 4'hF, 0, 1, 0, 0, 0, 0));
    step(mk(1, 1, 1, 16'h20, 4'hF, 32'hBAD0BAD0, 0, 0, 0, 0, 0), 1'b1, a);
    repeat (5) step(idle_v, 1'b0, a);
    issue(mk(1, 1, 1, 16'h20, 4'hF, 32'h12345678, 0, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 16'h20, 4'hF, 0, 1, 0, 0, 1, 32'h12345678));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
